// File: rtl/sc_mux4_lane_arbiter.sv
// Round-robin arbiter for one shared 2-bit stochastic-bitstream lane (4:1 mux).
// A winner holds the lane for a burst of BURST_LEN cycles (one bitstream), then the
// lane is re-arbitrated. Back-to-back bursts have no idle bubble.
// Optional feature macro: SC_ARB_EARLY_RELEASE_EN. When defined, a granted requester
// that drops its request ends its burst in that cycle.
module sc_mux4_lane_arbiter #(
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] arb_ptr;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       last_cycle;

  // At a burst end ptr_q is not yet updated, so scan from the current owner instead.
  assign arb_ptr = (state_q == StRun) ? sel_q : ptr_q;

  // Round-robin pick: first set request scanning upward from arb_ptr+1, wrapping.
  always_comb begin : pick_scan
    logic [1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = arb_ptr;
    cand       = arb_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = arb_ptr + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef SC_ARB_EARLY_RELEASE_EN
  // A dropped request on the owner ends the burst early; a drop on the final count
  // still yields a single last cycle.
  assign last_cycle = (state_q == StRun) && ((cnt_q == LastCnt) || !req[sel_q]);
`else
  assign last_cycle = (state_q == StRun) && (cnt_q == LastCnt);
`endif

  // Next-state logic: grant from idle, count through a burst, re-arbitrate at its end.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en && pick_valid) begin
          state_d = StRun;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
        end else begin
          gnt_d = '0;
        end
      end
      StRun: begin
        if (last_cycle) begin
          ptr_d = sel_q;
          cnt_d = '0;
          if (en && pick_valid) begin
            gnt_d = 4'b0001 << pick_idx;
            sel_d = pick_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; ptr resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign cnt        = cnt_q;
  assign busy       = (state_q == StRun);
  assign burst_done = last_cycle;

endmodule

// File: tb/tb_sc_mux4_lane_arbiter.sv
// Self-checking bench for sc_mux4_lane_arbiter (BURST_LEN=4 main instance, plus a
// BURST_LEN=1 instance sharing the same inputs for the single-cycle-burst case).
module tb_sc_mux4_lane_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;

  logic [3:0] gnt,  gnt1;
  logic [1:0] sel,  sel1;
  logic       busy, busy1;
  logic       done, done1;
  logic [1:0] cnt;
  logic [0:0] cnt1;

  sc_mux4_lane_arbiter #(.BURST_LEN(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .burst_done(done), .cnt(cnt)
  );

  sc_mux4_lane_arbiter #(.BURST_LEN(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .burst_done(done1), .cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic d, input logic [1:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.gnt = g; v.sel = s; v.busy = b; v.done = d; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;

    // Reset held with all requests asserted.
    add(1, 1, 4'hF, 4'h0, 0, 0, 0, 0);
    add(1, 1, 4'hF, 4'h0, 0, 0, 0, 0);
    // Release: idle one cycle, then full rotation 0,1,2,3 of 4-cycle bursts.
    add(0, 1, 4'hF, 4'h0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++)
      for (int c = 0; c < 4; c++)
        add(0, 1, 4'hF, 4'(1 << b), 2'(b), 1, c == 3, 2'(c));
    // Back to requester 0; only req 2 remains in its last cycle.
    for (int c = 0; c < 4; c++)
      add(0, 1, (c == 3) ? 4'b0100 : 4'hF, 4'b0001, 0, 1, c == 3, 2'(c));
    // Sole requester 2 regranted back-to-back; en drops in the final cycle.
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 4; c++)
        if (b == 1 && c == 3) add(0, 0, 4'b0010, 4'b0100, 2, 1, 1, 3);
        else                  add(0, 1, 4'b0100, 4'b0100, 2, 1, c == 3, 2'(c));
    // Disabled: no grant, sel holds.
    add(0, 0, 4'b0010, 4'h0, 2, 0, 0, 0);
    add(0, 0, 4'b0010, 4'h0, 2, 0, 0, 0);
    add(0, 1, 4'b0010, 4'h0, 2, 0, 0, 0);
    // Granted, en dropped at cnt=1: burst still completes.
    add(0, 1, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add(0, 0, 4'b0010, 4'b0010, 1, 1, 0, 1);
    add(0, 0, 4'b0010, 4'b0010, 1, 1, 0, 2);
    add(0, 0, 4'b0010, 4'b0010, 1, 1, 1, 3);
    add(0, 0, 4'b0010, 4'h0,    1, 0, 0, 0);
    // Grant 2, then reset mid-burst at cnt=2: cleared immediately, no done pulse.
    add(0, 1, 4'b0100, 4'h0,    1, 0, 0, 0);
    add(0, 1, 4'b0100, 4'b0100, 2, 1, 0, 0);
    add(0, 1, 4'b0100, 4'b0100, 2, 1, 0, 1);
    add(1, 1, 4'b0100, 4'h0,    0, 0, 0, 0);
    // Restart grants requester 0 first.
    add(0, 1, 4'hF,    4'h0,    0, 0, 0, 0);
    add(0, 1, 4'b0011, 4'b0001, 0, 1, 0, 0);
    // Owner 0 drops its request at cnt=1.
`ifdef SC_ARB_EARLY_RELEASE_EN
    add(0, 1, 4'b0010, 4'b0001, 0, 1, 1, 1);
    add(0, 1, 4'b0010, 4'b0010, 1, 1, 0, 0);
    add(0, 1, 4'b0010, 4'b0010, 1, 1, 0, 1);
    add(0, 1, 4'b0010, 4'b0010, 1, 1, 0, 2);
`else
    add(0, 1, 4'b0010, 4'b0001, 0, 1, 0, 1);
    add(0, 1, 4'b0010, 4'b0001, 0, 1, 0, 2);
    add(0, 1, 4'b0010, 4'b0001, 0, 1, 1, 3);
    add(0, 1, 4'b0010, 4'b0010, 1, 1, 0, 0);
`endif

    @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = ~vecs[i].rst;
      en    = vecs[i].en;
      req   = vecs[i].req;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check("gnt",        i, 32'(gnt),  32'(e.gnt));
      check("sel",        i, 32'(sel),  32'(e.sel));
      check("busy",       i, 32'(busy), 32'(e.busy));
      check("burst_done", i, 32'(done), 32'(e.done));
      check("cnt",        i, 32'(cnt),  32'(e.cnt));
      check("busy_eq_or_gnt", i, 32'(busy), 32'(|gnt));
      check("gnt_onehot0",    i, 32'($onehot0(gnt)), 32'd1);
    end

    // BURST_LEN=1 instance: reset, then grants rotate every cycle with done held high.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'hF;
    @(negedge clk);
    check("bl1_reset_gnt",  100, 32'(gnt1),  32'd0);
    check("bl1_reset_done", 100, 32'(done1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("bl1_idle_busy", 101, 32'(busy1), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bl1_gnt",  102 + k, 32'(gnt1),  32'(1 << (k % 4)));
      check("bl1_sel",  102 + k, 32'(sel1),  32'(k % 4));
      check("bl1_done", 102 + k, 32'(done1), 32'd1);
      check("bl1_cnt",  102 + k, 32'(cnt1),  32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
